kbd_dsp_pia: RTL and testbench

Apple-1 style keyboard/display port (6821 PIA subset) at 0xD010–0xD013, between the 6502 bus and the character devices. It buffers incoming keystrokes from the keyboard sources (UART RX, PS/2, USB) in a small FIFO and presents them as KBD/KBDCR. It latches CPU display writes (DSP) and hands them downstream to the VGA/UART sinks with a valid/ready handshake, exposing the busy bit the monitor polls.

---
 rtl/apple1_pkg.sv | 30 +++
 rtl/key_fifo.sv | 60 ++++++
 rtl/kbd_dsp_pia.sv | 115 +++++++++++
 tb/tb_kbd_dsp_pia.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// Shared definitions for the Apple-1 style PIA keyboard/display slice.
// Contents: PIA register offsets, key strobe bit, lowercase ASCII bounds,
// the key datapath width and the keystroke normalisation helper.
package apple1_pkg;

  // Register offsets within 0xD010-0xD013 (ab[1:0]).
  typedef enum logic [1:0] {
    PIA_KBD   = 2'd0,
    PIA_KBDCR = 2'd1,
    PIA_DSP   = 2'd2,
    PIA_DSPCR = 2'd3
  } pia_reg_e;

  localparam int         KEY_WIDTH         = 8;
  localparam logic [7:0] KEY_STROBE        = 8'h80;
  localparam logic [7:0] ASCII_LOWER_FIRST = 8'h61;
  localparam logic [7:0] ASCII_LOWER_LAST  = 8'h7A;

  // The monitor only understands upper case, and it expects every key
  // with bit7 set, as the original keyboard strobe delivered it.
  function automatic logic [7:0] fold_key(input logic [7:0] key);
    logic [7:0] folded;
    folded = key;
    if (key >= ASCII_LOWER_FIRST && key <= ASCII_LOWER_LAST) begin
      folded[5] = 1'b0;
    end
    return folded | KEY_STROBE;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO buffering normalised keystrokes until the CPU reads KBD.
// Ports: clk25/rst (async, active-high), push/din write side,
// pop/dout read side (dout is the current head, valid when !empty),
// full/empty status. Pushes while full and pops while empty are ignored.
module key_fifo
  import apple1_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = KEY_WIDTH
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty pointers already mask
  // stale entries, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk25) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kbd_dsp_pia.sv
// Apple-1 keyboard/display port (6821 PIA subset) at 0xD010-0xD013.
// Ports: clk25/rst (async, active-high); CPU bus enable/cs/address/w_en/
// din/dout; keyboard source key_valid/key_data/key_ready; display sink
// dsp_valid/dsp_data/dsp_ready. Holds bus decode, key case fold, the
// display latch with its busy handshake, and the sticky drop flag.
module kbd_dsp_pia
  import apple1_pkg::*;
#(
  parameter int KEY_FIFO_DEPTH = 4
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       enable,
  input  logic       cs,
  input  logic [1:0] address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  output logic       dsp_valid,
  output logic [6:0] dsp_data,
  input  logic       dsp_ready
);

  pia_reg_e   reg_sel;
  logic       bus_rd;
  logic       bus_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic       key_pop;
  logic [7:0] key_head;

  logic       busy_q, busy_d;
  logic [6:0] dsp_data_q, dsp_data_d;
  logic       drop_q, drop_d;

  // Bit 7 of a display write has no meaning on this port.
  logic       unused_din_msb;
  assign unused_din_msb = din[7];

  assign reg_sel = pia_reg_e'(address);
  assign bus_rd  = cs && enable && !w_en;
  assign bus_wr  = cs && enable && w_en;
  assign key_pop = bus_rd && (reg_sel == PIA_KBD);

  // Key pushes run on clk25 alone; the keyboard sources do not know about
  // the CPU clock enable.
  key_fifo #(
    .DEPTH(KEY_FIFO_DEPTH),
    .WIDTH(KEY_WIDTH)
  ) u_key_fifo (
    .clk25 (clk25),
    .rst   (rst),
    .push  (key_valid),
    .pop   (key_pop),
    .din   (fold_key(key_data)),
    .dout  (key_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign key_ready = !fifo_full;
  assign dsp_valid = busy_q;
  assign dsp_data  = dsp_data_q;

  // A write arriving on the handshake edge sees busy still set and is
  // dropped; the CPU is expected to poll DSP bit7 first.
  always_comb begin
    busy_d     = busy_q;
    dsp_data_d = dsp_data_q;
    drop_d     = drop_q;
    if (busy_q && dsp_ready) busy_d = 1'b0;
    if (bus_wr && reg_sel == PIA_DSP) begin
      if (busy_q) begin
        drop_d = 1'b1;
      end else begin
        dsp_data_d = din[6:0];
        busy_d     = 1'b1;
      end
    end
    if (bus_wr && reg_sel == PIA_DSPCR) drop_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      dsp_data_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      dsp_data_q <= dsp_data_d;
      drop_q     <= drop_d;
    end
  end

  // Read mux depends only on registered state and the address; it is not
  // gated by enable so the value is stable across the whole CPU cycle.
  always_comb begin
    dout = 8'h00;
    if (cs) begin
      case (reg_sel)
        PIA_KBD:   dout = fifo_empty ? 8'h00 : key_head;
        PIA_KBDCR: dout = {!fifo_empty, 7'b0};
        PIA_DSP:   dout = {busy_q, dsp_data_q};
        PIA_DSPCR: dout = {7'b0, drop_q};
        default:   dout = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_dsp_pia.sv
module tb_kbd_dsp_pia;

  localparam int DEPTH = 4;
  localparam logic [1:0] A_KBD = 2'd0, A_KBDCR = 2'd1, A_DSP = 2'd2, A_DSPCR = 2'd3;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       enable;
  logic       cs;
  logic [1:0] address;
  logic       w_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready;
  logic       dsp_valid;
  logic [6:0] dsp_data;
  logic       dsp_ready;

  int checks   = 0;
  int failures = 0;

  // Scoreboards: expected KBD bytes and expected display characters.
  logic [7:0] kq[$];
  logic [6:0] dq[$];

  typedef struct {
    logic [7:0] key;
    logic [7:0] exp;
  } fold_vec_t;
  fold_vec_t fold_tbl[8];

  kbd_dsp_pia #(.KEY_FIFO_DEPTH(DEPTH)) dut (
    .clk25     (clk25),
    .rst       (rst),
    .enable    (enable),
    .cs        (cs),
    .address   (address),
    .w_en      (w_en),
    .din       (din),
    .dout      (dout),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data),
    .dsp_ready (dsp_ready)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  // Look at a register without any bus action (enable low).
  task automatic peek(input logic [1:0] a, input string name, input logic [7:0] exp);
    cs = 1'b1; enable = 1'b0; w_en = 1'b0; address = a;
    #1;
    check(name, dout, exp);
    cs = 1'b0; enable = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; enable = 1'b1; w_en = 1'b1; address = a; din = d;
    step();
    cs = 1'b0; w_en = 1'b0;
  endtask

  task automatic kbd_read(input string name);
    logic [7:0] exp;
    cs = 1'b1; enable = 1'b1; w_en = 1'b0; address = A_KBD;
    #1;
    exp = (kq.size() > 0) ? kq.pop_front() : 8'h00;
    check(name, dout, exp);
    step();
    cs = 1'b0;
  endtask

  task automatic key_push(input logic [7:0] k, input logic [7:0] exp);
    logic room;
    room = (kq.size() < DEPTH);
    key_valid = 1'b1; key_data = k;
    #1;
    check("key_ready", {7'b0, key_ready}, {7'b0, room});
    if (room) kq.push_back(exp);
    step();
    key_valid = 1'b0;
  endtask

  // Checks the character offered at a handshake against the scoreboard.
  task automatic check_offer(input string name);
    logic [6:0] exp;
    exp = (dq.size() > 0) ? dq.pop_front() : 7'h7F;
    check({name, "_valid"}, {7'b0, dsp_valid}, 8'h01);
    check({name, "_data"}, {1'b0, dsp_data}, {1'b0, exp});
  endtask

  initial begin
    fold_tbl[0] = '{8'h61, 8'hC1};
    fold_tbl[1] = '{8'h7A, 8'hDA};
    fold_tbl[2] = '{8'h60, 8'hE0};
    fold_tbl[3] = '{8'h7B, 8'hFB};
    fold_tbl[4] = '{8'h41, 8'hC1};
    fold_tbl[5] = '{8'h5A, 8'hDA};
    fold_tbl[6] = '{8'h31, 8'hB1};
    fold_tbl[7] = '{8'h0D, 8'h8D};

    rst = 1'b1; enable = 1'b1; cs = 1'b0; address = 2'd0; w_en = 1'b0;
    din = 8'h00; key_valid = 1'b0; key_data = 8'h00; dsp_ready = 1'b0;
    #5;
    check("rst_key_ready", {7'b0, key_ready}, 8'h01);
    check("rst_dsp_valid", {7'b0, dsp_valid}, 8'h00);
    check("rst_dsp_data", {1'b0, dsp_data}, 8'h00);
    check("rst_dout_nocs", dout, 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    peek(A_KBDCR, "rst_kbdcr", 8'h00);
    peek(A_DSP, "rst_dsp", 8'h00);
    peek(A_DSPCR, "rst_dspcr", 8'h00);

    // Single key, then reads on an empty FIFO.
    key_push(8'h61, 8'hC1);
    peek(A_KBDCR, "kbdcr_after_push", 8'h80);
    kbd_read("kbd_first");
    peek(A_KBDCR, "kbdcr_after_pop", 8'h00);
    peek(A_KBD, "kbd_empty", 8'h00);
    kbd_read("kbd_empty_rd");
    peek(A_KBDCR, "kbdcr_empty_rd", 8'h00);

    // Case fold / strobe table.
    for (int i = 0; i < 8; i++) begin
      key_push(fold_tbl[i].key, fold_tbl[i].exp);
      kbd_read($sformatf("fold_%0d", i));
    end

    // Fill to full, overflow attempt, drain in order.
    key_push(8'h31, 8'hB1);
    key_push(8'h32, 8'hB2);
    key_push(8'h33, 8'hB3);
    key_push(8'h34, 8'hB4);
    key_push(8'h35, 8'hB5);
    for (int i = 0; i < DEPTH; i++) kbd_read($sformatf("drain_%0d", i));
    kbd_read("drain_empty");

    // Display write held by the sink, then a dropped write.
    dsp_ready = 1'b0;
    bus_write(A_DSP, 8'hC8);
    dq.push_back(7'h48);
    check("dsp_valid_set", {7'b0, dsp_valid}, 8'h01);
    peek(A_DSP, "dsp_busy_rd", 8'hC8);
    bus_write(A_DSP, 8'h41);
    check("dsp_data_hold", {1'b0, dsp_data}, 8'h48);
    peek(A_DSPCR, "dspcr_drop", 8'h01);
    bus_write(A_DSPCR, 8'h00);
    peek(A_DSPCR, "dspcr_clear", 8'h00);
    dsp_ready = 1'b1;
    check_offer("hs1");
    step();
    dsp_ready = 1'b0;
    check("hs1_done", {7'b0, dsp_valid}, 8'h00);
    peek(A_DSP, "dsp_idle_rd", 8'h48);

    // Push and pop in the same cycle with two entries held.
    key_push(8'h41, 8'hC1);
    key_push(8'h42, 8'hC2);
    key_valid = 1'b1; key_data = 8'h63;
    cs = 1'b1; enable = 1'b1; w_en = 1'b0; address = A_KBD;
    #1;
    check("pushpop_head", dout, kq.pop_front());
    kq.push_back(8'hC3);
    step();
    key_valid = 1'b0; cs = 1'b0;
    kbd_read("pushpop_1");
    kbd_read("pushpop_2");
    kbd_read("pushpop_empty");

    // Display write on the handshake edge is dropped.
    bus_write(A_DSP, 8'h55);
    dq.push_back(7'h55);
    dsp_ready = 1'b1;
    cs = 1'b1; enable = 1'b1; w_en = 1'b1; address = A_DSP; din = 8'h66;
    #1;
    check_offer("hs2");
    step();
    cs = 1'b0; w_en = 1'b0; dsp_ready = 1'b0;
    check("hs2_done", {7'b0, dsp_valid}, 8'h00);
    check("hs2_data", {1'b0, dsp_data}, 8'h55);
    peek(A_DSPCR, "hs2_drop", 8'h01);
    bus_write(A_DSPCR, 8'hFF);

    // Back-to-back writes two cycles apart with the sink always ready.
    dsp_ready = 1'b1;
    bus_write(A_DSP, 8'h11);
    dq.push_back(7'h11);
    check_offer("b2b1");
    step();
    check("b2b_gap", {7'b0, dsp_valid}, 8'h00);
    bus_write(A_DSP, 8'h12);
    dq.push_back(7'h12);
    check_offer("b2b2");
    peek(A_DSPCR, "b2b_nodrop", 8'h00);
    step();
    dsp_ready = 1'b0;

    // Bus strobes with enable low do nothing.
    key_push(8'h58, 8'hD8);
    cs = 1'b1; enable = 1'b0; w_en = 1'b0; address = A_KBD;
    step();
    w_en = 1'b1; address = A_DSP; din = 8'h77;
    step();
    cs = 1'b0; enable = 1'b1; w_en = 1'b0;
    check("noen_dsp_valid", {7'b0, dsp_valid}, 8'h00);
    peek(A_KBDCR, "noen_kbdcr", 8'h80);
    kbd_read("noen_kbd");

    // Asynchronous reset mid-handshake with a full FIFO and drop set.
    for (int i = 0; i < DEPTH; i++) key_push(8'h70 + 8'(i), 8'hD0 + 8'(i));
    bus_write(A_DSP, 8'h5A);
    bus_write(A_DSP, 8'h5B);
    check("pre_rst_full", {7'b0, key_ready}, 8'h00);
    dsp_ready = 1'b1;
    #5 rst = 1'b1;
    #1;
    check("arst_key_ready", {7'b0, key_ready}, 8'h01);
    check("arst_dsp_valid", {7'b0, dsp_valid}, 8'h00);
    check("arst_dsp_data", {1'b0, dsp_data}, 8'h00);
    check("arst_dout_nocs", dout, 8'h00);
    peek(A_KBDCR, "arst_kbdcr", 8'h00);
    peek(A_DSPCR, "arst_dspcr", 8'h00);
    kq.delete();
    dq.delete();
    dsp_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    key_push(8'h7A, 8'hDA);
    kbd_read("post_rst_kbd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
